// File: rtl/lpif_txrx_asym_credit_master.sv
`default_nettype none
// ==========================================================================
// lpif_txrx_asym_credit_master: LPIF master link core with credited TX FIFO
// Revision: 1.0
// ==========================================================================
module lpif_txrx_asym_credit_master #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_CH       = 2,
  parameter int CH_WIDTH     = 40,
  parameter int FIFO_DEPTH   = 8,
  parameter int CREDIT_WIDTH = 8,
  parameter int STB_INTERVAL = 16
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr_n,
  input  logic                       tx_online,
  input  logic                       rx_online,
  input  logic [15:0]                delay_x_value,
  input  logic [15:0]                delay_y_value,
  input  logic [CREDIT_WIDTH-1:0]    init_downstream_credit,
  input  logic                       tx_mrk_userbit,
  input  logic                       tx_stb_userbit,
  input  logic [3:0]                 dstrm_state,
  input  logic [1:0]                 dstrm_protid,
  input  logic [DATA_WIDTH-1:0]      dstrm_data,
  input  logic                       dstrm_dvalid,
  input  logic [1:0]                 dstrm_crc,
  input  logic                       dstrm_crc_valid,
  input  logic                       dstrm_valid,
  output logic                       dstrm_ready,
  output logic [3:0]                 ustrm_state,
  output logic [1:0]                 ustrm_protid,
  output logic [DATA_WIDTH-1:0]      ustrm_data,
  output logic                       ustrm_dvalid,
  output logic [1:0]                 ustrm_crc,
  output logic                       ustrm_crc_valid,
  output logic                       ustrm_valid,
  output logic [NUM_CH*CH_WIDTH-1:0] tx_phy,
  input  logic [NUM_CH*CH_WIDTH-1:0] rx_phy,
  output logic [31:0]                debug_status
);

  localparam int FLIT_W = DATA_WIDTH + 11;
  localparam int PAY_W  = NUM_CH * (CH_WIDTH - 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int SW     = $clog2(STB_INTERVAL);

  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_COUNT   = 2'd1,
    ST_ONLINE  = 2'd2
  } dly_state_e;

  // Index 0 is the TX direction, index 1 the RX direction.
  logic [1:0]       online_in;
  logic [1:0]       online_dly;
  logic [1:0][15:0] dly_val;

  assign online_in = {rx_online, tx_online};
  assign dly_val   = {delay_x_value, delay_y_value};

  for (genvar g = 0; g < 2; g++) begin : g_dly
    dly_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_OFFLINE: if (online_in[g]) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
        ST_COUNT: begin
          if (!online_in[g])               state_d = ST_OFFLINE;
          else if (cnt_q == dly_val[g])    state_d = ST_ONLINE;
          else                             cnt_d   = cnt_q + 16'd1;
        end
        ST_ONLINE: if (!online_in[g]) state_d = ST_OFFLINE;
        default: state_d = ST_OFFLINE;
      endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
        state_q <= ST_OFFLINE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign online_dly[g] = (state_q == ST_ONLINE);
  end

  logic                       tx_on, rx_on;
  logic [PAY_W-1:0]           rx_pay, tx_pay;
  logic [FLIT_W-1:0]          rx_flit, dstrm_flit;
  logic                       rx_fv, rx_cr, cr_in;
  logic                       push, pop, empty, full;
  logic                       mrk_bit, stb_bit;

  logic [FLIT_W-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              count_q, count_d;
  logic                       ready_q, ready_d;
  logic [CREDIT_WIDTH-1:0]    credit_q, credit_d;
  logic                       ovf_q, ovf_d, crovf_q, crovf_d;
  logic [SW-1:0]              stb_cnt_q, stb_cnt_d;
  logic [NUM_CH*CH_WIDTH-1:0] tx_phy_q, tx_phy_d;
  logic [FLIT_W-1:0]          ustrm_flit_q, ustrm_flit_d;
  logic                       ustrm_valid_q, ustrm_valid_d;

  assign tx_on = online_dly[0];
  assign rx_on = online_dly[1];

  // Flit layout, MSB first: state, protid, data, dvalid, crc, crc_valid, valid.
  assign dstrm_flit = {dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
                       dstrm_crc, dstrm_crc_valid, 1'b1};

  always_comb begin
    rx_pay = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rx_pay[c*(CH_WIDTH-1) +: CH_WIDTH-1] = rx_phy[c*CH_WIDTH +: CH_WIDTH-1];
    end
  end

  assign rx_flit = rx_pay[FLIT_W-1:0];
  assign rx_fv   = rx_pay[FLIT_W];
  assign rx_cr   = rx_pay[FLIT_W+1];
  assign cr_in   = rx_on & rx_cr;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(FIFO_DEPTH));
  assign pop   = tx_on & ~empty & (credit_q != '0);
  assign push  = dstrm_valid & ready_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + LW'(push) - LW'(pop);
    ready_d  = (count_d != LW'(FIFO_DEPTH));
    ovf_d    = ovf_q | (dstrm_valid & full);
  end

  // Credit tracks the remote FIFO; it is pinned to the init value while offline.
  always_comb begin
    credit_d = credit_q;
    crovf_d  = crovf_q;
    if (!tx_on) begin
      credit_d = init_downstream_credit;
    end else if (cr_in && !pop) begin
      if (credit_q == '1) crovf_d  = 1'b1;
      else                credit_d = credit_q + CREDIT_WIDTH'(1);
    end else if (pop && !cr_in) begin
      credit_d = credit_q - CREDIT_WIDTH'(1);
    end
  end

  always_comb begin
    stb_cnt_d = '0;
    if (tx_on && stb_cnt_q != SW'(STB_INTERVAL-1)) stb_cnt_d = stb_cnt_q + SW'(1);
    mrk_bit = tx_mrk_userbit & tx_on;
    stb_bit = tx_stb_userbit & (stb_cnt_q == '0) & tx_on;
  end

  always_comb begin
    tx_pay = '0;
    if (pop) begin
      tx_pay[FLIT_W-1:0] = mem_q[rd_ptr_q];
      tx_pay[FLIT_W]     = 1'b1;
    end
    tx_pay[FLIT_W+1] = rx_on & rx_fv;
    tx_phy_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tx_phy_d[c*CH_WIDTH +: CH_WIDTH-1] = tx_pay[c*(CH_WIDTH-1) +: CH_WIDTH-1];
      tx_phy_d[c*CH_WIDTH + CH_WIDTH-1]  = (c == 0) ? mrk_bit : stb_bit;
    end
  end

  always_comb begin
    ustrm_valid_d = rx_on & rx_fv;
    ustrm_flit_d  = ustrm_valid_d ? rx_flit : ustrm_flit_q;
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk_wr) begin
    if (push) mem_q[wr_ptr_q] <= dstrm_flit;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      credit_q      <= '0;
      ovf_q         <= 1'b0;
      crovf_q       <= 1'b0;
      stb_cnt_q     <= '0;
      tx_phy_q      <= '0;
      ustrm_flit_q  <= '0;
      ustrm_valid_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      credit_q      <= credit_d;
      ovf_q         <= ovf_d;
      crovf_q       <= crovf_d;
      stb_cnt_q     <= stb_cnt_d;
      tx_phy_q      <= tx_phy_d;
      ustrm_flit_q  <= ustrm_flit_d;
      ustrm_valid_q <= ustrm_valid_d;
    end
  end

  assign dstrm_ready     = ready_q;
  assign tx_phy          = tx_phy_q;
  assign ustrm_valid     = ustrm_valid_q;
  assign ustrm_state     = ustrm_flit_q[FLIT_W-1 -: 4];
  assign ustrm_protid    = ustrm_flit_q[FLIT_W-5 -: 2];
  assign ustrm_data      = ustrm_flit_q[5 +: DATA_WIDTH];
  assign ustrm_dvalid    = ustrm_flit_q[4];
  assign ustrm_crc       = ustrm_flit_q[3:2];
  assign ustrm_crc_valid = ustrm_flit_q[1];

  assign debug_status = {8'(credit_q), 8'(count_q), tx_on, rx_on, ovf_q, crovf_q, 12'd0};

  // Sync bits, pad and the rx per-flit valid bit carry no information here.
  logic unused_rx;
  assign unused_rx = ^{rx_phy, rx_pay, ustrm_flit_q[0]};

endmodule
`default_nettype wire

// File: tb/tb_lpif_txrx_asym_credit_master.sv
`default_nettype none
// ==========================================================================
// tb_lpif_txrx_asym_credit_master: directed bench with flit scoreboard
// Revision: 1.0
// ==========================================================================
module tb_lpif_txrx_asym_credit_master;

  localparam int DW     = 64;
  localparam int NCH    = 2;
  localparam int CHW    = 40;
  localparam int CRW    = 8;
  localparam int FLIT_W = DW + 11;
  localparam int PAY_W  = NCH * (CHW - 1);

  logic              clk, rst_n;
  logic              tx_online, rx_online;
  logic [15:0]       delay_x, delay_y;
  logic [CRW-1:0]    init_cr;
  logic              mrk, stb;
  logic [3:0]        d_state;
  logic [1:0]        d_protid;
  logic [DW-1:0]     d_data;
  logic              d_dvalid;
  logic [1:0]        d_crc;
  logic              d_crc_valid;
  logic              d_valid;
  logic              d_ready;
  logic [3:0]        u_state;
  logic [1:0]        u_protid;
  logic [DW-1:0]     u_data;
  logic              u_dvalid;
  logic [1:0]        u_crc;
  logic              u_crc_valid;
  logic              u_valid;
  logic [NCH*CHW-1:0] tx_phy, rx_phy;
  logic [31:0]       dbg;

  int checks = 0;
  int errors = 0;
  int sent   = 0;
  logic [FLIT_W-1:0] sb [$];

  lpif_txrx_asym_credit_master #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_WIDTH(CHW),
    .FIFO_DEPTH(8), .CREDIT_WIDTH(CRW), .STB_INTERVAL(16)
  ) dut (
    .clk_wr(clk), .rst_wr_n(rst_n),
    .tx_online(tx_online), .rx_online(rx_online),
    .delay_x_value(delay_x), .delay_y_value(delay_y),
    .init_downstream_credit(init_cr),
    .tx_mrk_userbit(mrk), .tx_stb_userbit(stb),
    .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data),
    .dstrm_dvalid(d_dvalid), .dstrm_crc(d_crc), .dstrm_crc_valid(d_crc_valid),
    .dstrm_valid(d_valid), .dstrm_ready(d_ready),
    .ustrm_state(u_state), .ustrm_protid(u_protid), .ustrm_data(u_data),
    .ustrm_dvalid(u_dvalid), .ustrm_crc(u_crc), .ustrm_crc_valid(u_crc_valid),
    .ustrm_valid(u_valid),
    .tx_phy(tx_phy), .rx_phy(rx_phy), .debug_status(dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [3:0] st, input logic [1:0] pid,
      input logic [DW-1:0] d, input logic dv, input logic [1:0] crc, input logic crcv);
    return {st, pid, d, dv, crc, crcv, 1'b1};
  endfunction

  function automatic logic [FLIT_W-1:0] rand_flit();
    return mk_flit(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endfunction

  function automatic logic [PAY_W-1:0] get_tx_pay();
    logic [PAY_W-1:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) p[c*(CHW-1) +: CHW-1] = tx_phy[c*CHW +: CHW-1];
    return p;
  endfunction

  function automatic logic [NCH*CHW-1:0] mk_rx(input logic [FLIT_W-1:0] f, input logic fv,
                                                input logic cr);
    logic [PAY_W-1:0]   p;
    logic [NCH*CHW-1:0] w;
    p = '0;
    p[FLIT_W-1:0] = f;
    p[FLIT_W]     = fv;
    p[FLIT_W+1]   = cr;
    w = '0;
    for (int c = 0; c < NCH; c++) w[c*CHW +: CHW-1] = p[c*(CHW-1) +: CHW-1];
    return w;
  endfunction

  // One clock; every flit appearing on tx_phy is matched against the scoreboard.
  task automatic tick();
    logic [PAY_W-1:0]  p;
    logic [FLIT_W-1:0] e;
    @(posedge clk);
    #1;
    p = get_tx_pay();
    if (p[FLIT_W]) begin
      sent++;
      if (sb.size() == 0) begin
        check("tx_unexpected_flit_sb_size", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        check("tx_flit", 128'(p[FLIT_W-1:0]), 128'(e));
      end
    end
  endtask

  task automatic push_flit(input logic [FLIT_W-1:0] f, input logic expect_ready);
    logic rdy;
    d_state     = f[FLIT_W-1 -: 4];
    d_protid    = f[FLIT_W-5 -: 2];
    d_data      = f[5 +: DW];
    d_dvalid    = f[4];
    d_crc       = f[3:2];
    d_crc_valid = f[1];
    d_valid     = 1'b1;
    rdy         = d_ready;
    check("dstrm_ready", 128'(rdy), 128'(expect_ready));
    tick();
    if (rdy) sb.push_back(f);
  endtask

  initial begin
    logic [FLIT_W-1:0] uf;
    int last, npulse;

    rst_n = 1'b0; tx_online = 0; rx_online = 0; delay_x = 0; delay_y = 5;
    init_cr = 8'd3; mrk = 0; stb = 0; d_valid = 0; d_state = 0; d_protid = 0;
    d_data = 0; d_dvalid = 0; d_crc = 0; d_crc_valid = 0; rx_phy = '0;
    repeat (3) tick();
    check("rst_tx_phy", 128'(tx_phy), 128'd0);
    check("rst_debug", 128'(dbg), 128'd0);
    check("rst_ready", 128'(d_ready), 128'd0);
    check("rst_ustrm_valid", 128'(u_valid), 128'd0);
    rst_n = 1'b1;

    // Online delay: COUNT on first edge, ONLINE six edges later for delay 5
    tx_online = 1'b1;
    repeat (6) tick();
    check("tx_dly_before", 128'(dbg[15]), 128'd0);
    tick();
    check("tx_dly_online", 128'(dbg[15]), 128'd1);
    check("credit_loaded", 128'(dbg[31:24]), 128'd3);
    tx_online = 1'b0;
    tick();
    check("tx_dly_drop", 128'(dbg[15]), 128'd0);
    delay_y = 0; tx_online = 1'b1; rx_online = 1'b1;
    tick();
    check("tx_dly0_count", 128'(dbg[15]), 128'd0);
    tick();
    check("tx_dly0_online", 128'(dbg[15]), 128'd1);
    check("rx_dly0_online", 128'(dbg[14]), 128'd1);

    // Credit gating: 5 flits, 3 credits
    for (int i = 0; i < 5; i++) push_flit(rand_flit(), 1'b1);
    d_valid = 1'b0;
    repeat (3) tick();
    check("sent_3", 128'(sent), 128'd3);
    check("credit_0", 128'(dbg[31:24]), 128'd0);
    check("level_2", 128'(dbg[23:16]), 128'd2);
    rx_phy = mk_rx('0, 1'b0, 1'b1);
    repeat (2) tick();
    rx_phy = '0;
    repeat (2) tick();
    check("sent_5", 128'(sent), 128'd5);
    check("credit_0b", 128'(dbg[31:24]), 128'd0);
    check("level_0", 128'(dbg[23:16]), 128'd0);

    // Fill to full at zero credit, then overflow
    for (int i = 0; i < 8; i++) push_flit(rand_flit(), 1'b1);
    d_valid = 1'b0;
    check("full_ready", 128'(d_ready), 128'd0);
    check("full_level", 128'(dbg[23:16]), 128'd8);
    check("ovf_clear", 128'(dbg[13]), 128'd0);
    push_flit(rand_flit(), 1'b0);
    d_valid = 1'b0;
    check("ovf_set", 128'(dbg[13]), 128'd1);
    check("ovf_level", 128'(dbg[23:16]), 128'd8);
    // Drop online, reload 8 credits and drain in order
    tx_online = 1'b0; init_cr = 8'd8;
    repeat (2) tick();
    tx_online = 1'b1;
    repeat (12) tick();
    check("drain_sent", 128'(sent), 128'd13);
    check("drain_sb_empty", 128'(sb.size()), 128'd0);
    check("drain_level", 128'(dbg[23:16]), 128'd0);

    // Upstream flit and credit return
    uf = mk_flit(4'hA, 2'h2, 64'hDEAD_BEEF_0123_4567, 1'b1, 2'h1, 1'b1);
    rx_phy = mk_rx(uf, 1'b1, 1'b0);
    tick();
    rx_phy = '0;
    check("ustrm_data", 128'(u_data), 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
    check("ustrm_state", 128'(u_state), 128'hA);
    check("ustrm_protid", 128'(u_protid), 128'h2);
    check("ustrm_crc", 128'({u_dvalid, u_crc, u_crc_valid}), 128'hB);
    check("ustrm_valid", 128'(u_valid), 128'd1);
    check("tx_credit_ret", 128'(get_tx_pay() >> (FLIT_W + 1)), 128'd1);
    tick();
    check("ustrm_valid_pulse", 128'(u_valid), 128'd0);
    check("ustrm_data_hold", 128'(u_data), 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
    check("tx_credit_ret_clr", 128'(get_tx_pay() >> (FLIT_W + 1)), 128'd0);

    // Credit saturation
    tx_online = 1'b0; init_cr = 8'd255;
    repeat (2) tick();
    tx_online = 1'b1;
    repeat (2) tick();
    check("credit_255", 128'(dbg[31:24]), 128'd255);
    check("crovf_clear", 128'(dbg[12]), 128'd0);
    rx_phy = mk_rx('0, 1'b0, 1'b1);
    tick();
    rx_phy = '0;
    check("credit_sat", 128'(dbg[31:24]), 128'd255);
    check("crovf_set", 128'(dbg[12]), 128'd1);

    // Simultaneous pop and return at credit 4
    tx_online = 1'b0;
    tick();
    push_flit(rand_flit(), 1'b1);
    d_valid = 1'b0; init_cr = 8'd4;
    tick();
    tx_online = 1'b1;
    repeat (2) tick();
    check("credit_4", 128'(dbg[31:24]), 128'd4);
    rx_phy = mk_rx('0, 1'b0, 1'b1);
    tick();
    rx_phy = '0;
    check("credit_pop_ret", 128'(dbg[31:24]), 128'd4);
    check("pop_ret_level", 128'(dbg[23:16]), 128'd0);
    check("pop_ret_sent", 128'(sent), 128'd14);

    // Strobe and marker
    stb = 1'b1; mrk = 1'b1;
    tick();
    check("marker_bit", 128'(tx_phy[CHW-1]), 128'd1);
    last = -1; npulse = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (tx_phy[2*CHW-1]) begin
        if (last >= 0) check("stb_gap", 128'(i - last), 128'd16);
        last = i;
        npulse++;
      end
    end
    check("stb_count", 128'(npulse), 128'd3);

    // Asynchronous reset in the middle of traffic
    push_flit(rand_flit(), 1'b1);
    push_flit(rand_flit(), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    d_valid = 1'b0;
    check("arst_tx_phy", 128'(tx_phy), 128'd0);
    check("arst_debug", 128'(dbg), 128'd0);
    check("arst_ready", 128'(d_ready), 128'd0);
    check("arst_ustrm", 128'({u_valid, u_state, u_protid, u_data, u_dvalid, u_crc, u_crc_valid}),
          128'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
